// File: rtl/fcmp_pipe.sv
// fcmp_pipe: pipelined floating-point compare unit (FEQ / FLT / FLE).
//
// Operands are {sign, exp[EXP_W-1:0], man[MAN_W-1:0]}. Results leave on a
// valid/ready stream. The whole pipe advances or holds as one unit, and
// there is no bubble collapsing.
//
// Optional feature: define FCMP_NAN_EN to enable NaN detection, which gives
// unordered results and sets the invalid flag. Without it, all-ones exponents
// compare as ordinary magnitudes, and nv is raised only for the reserved op.
//
// Ports:
//   sys_clk    clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   unit accepts a beat this cycle (combinational)
//   op         00 FEQ, 01 FLT, 10 FLE, 11 reserved
//   x1, x2     operands a and b
//   y          compare result (registered)
//   nv         invalid-operation flag for this result (registered)
//   out_valid  result valid
//   out_ready  consumer accepts result
module fcmp_pipe #(
  parameter int EXP_W         = 8,
  parameter int MAN_W         = 23,
  parameter int STAGES        = 2,
  parameter int OUT_W         = 32,
  parameter int TRUE_ALL_ONES = 1
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  output logic [OUT_W-1:0]       y,
  output logic                   nv,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);
  localparam logic [OUT_W-1:0] ONES     = '1;
  localparam logic [OUT_W-1:0] TRUE_VAL = (TRUE_ALL_ONES != 0) ? ONES : ONE;

  typedef enum logic [1:0] {
    OP_FEQ = 2'b00,
    OP_FLT = 2'b01,
    OP_FLE = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // Maps the decoded compare bits to {result, nv} for the selected mode.
  function automatic logic [1:0] resolve(input logic [1:0] o,
                                         input logic eq,
                                         input logic lt,
                                         input logic nan,
                                         input logic snan);
    logic [1:0] r;
    case (op_e'(o))
      OP_FEQ:  r = {eq & ~nan, snan};
      OP_FLT:  r = {lt & ~nan, nan};
      OP_FLE:  r = {(lt | eq) & ~nan, nan};
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand decode
  // ---------------------------------------------------------------------------
  logic                   a_sign, b_sign;
  logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
  logic                   a_zero, b_zero, both_zero;
  logic                   d_eq, d_lt, d_nan, d_snan;

`ifdef FCMP_NAN_EN
  logic a_nan, b_nan, a_snan, b_snan;
`endif

  always_comb begin
    a_sign    = x1[W-1];
    b_sign    = x2[W-1];
    a_mag     = x1[W-2:0];
    b_mag     = x2[W-2:0];
    a_zero    = (a_mag == '0);
    b_zero    = (b_mag == '0);
    both_zero = a_zero & b_zero;

    d_eq = (x1 == x2) | both_zero;

    if (both_zero)
      d_lt = 1'b0;
    else if (a_sign != b_sign)
      d_lt = a_sign;
    else if (!a_sign)
      d_lt = (a_mag < b_mag);
    else
      d_lt = (a_mag > b_mag);

`ifdef FCMP_NAN_EN
    a_nan  = (&x1[W-2:MAN_W]) & (|x1[MAN_W-1:0]);
    b_nan  = (&x2[W-2:MAN_W]) & (|x2[MAN_W-1:0]);
    a_snan = a_nan & ~x1[MAN_W-1];
    b_snan = b_nan & ~x2[MAN_W-1];
    d_nan  = a_nan | b_nan;
    d_snan = a_snan | b_snan;
`else
    d_nan  = 1'b0;
    d_snan = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Flow control: the whole pipe moves only when the output slot frees up.
  // ---------------------------------------------------------------------------
  logic advance;
  logic last_v, last_r, last_n;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~rst;

  generate
    if (STAGES == 1) begin : g_one
      // A single stage must already hold the final result so that y stays
      // registered; mode resolution therefore happens before the flop here.
      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          last_v <= 1'b0;
          last_r <= 1'b0;
          last_n <= 1'b0;
        end else if (advance) begin
          last_v           <= in_valid;
          {last_r, last_n} <= resolve(op, d_eq, d_lt, d_nan, d_snan);
        end
      end
    end else begin : g_multi
      logic             s1_v, s1_eq, s1_lt, s1_nan, s1_snan;
      logic [1:0]       s1_op;
      logic             s1_r, s1_n;
      logic [STAGES-2:0] v_q, r_q, n_q;
      logic [STAGES-1:0] v_cat, r_cat, n_cat;

      assign {s1_r, s1_n} = resolve(s1_op, s1_eq, s1_lt, s1_nan, s1_snan);

      // Stage-1 output is the entry point of the {valid, result, nv} shift
      // chain; the top bit of each concatenation is the last stage.
      assign v_cat = {v_q, s1_v};
      assign r_cat = {r_q, s1_r};
      assign n_cat = {n_q, s1_n};

      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          s1_v    <= 1'b0;
          s1_eq   <= 1'b0;
          s1_lt   <= 1'b0;
          s1_nan  <= 1'b0;
          s1_snan <= 1'b0;
          s1_op   <= '0;
          v_q     <= '0;
          r_q     <= '0;
          n_q     <= '0;
        end else if (advance) begin
          s1_v    <= in_valid;
          s1_eq   <= d_eq;
          s1_lt   <= d_lt;
          s1_nan  <= d_nan;
          s1_snan <= d_snan;
          s1_op   <= op;
          v_q     <= v_cat[STAGES-2:0];
          r_q     <= r_cat[STAGES-2:0];
          n_q     <= n_cat[STAGES-2:0];
        end
      end

      assign last_v = v_cat[STAGES-1];
      assign last_r = r_cat[STAGES-1];
      assign last_n = n_cat[STAGES-1];
    end
  endgenerate

  assign out_valid = last_v;
  assign nv        = last_n;
  assign y         = last_r ? TRUE_VAL : '0;

endmodule
